// File: rtl/obs_game_pkg.sv
// Shared constants for the obstacle field: geometry, lane encodings, LFSR taps/seed
// and the generated-row mapping that always leaves one lane free.
package obs_game_pkg;

  localparam int unsigned LANES  = 3;
  localparam int unsigned ROWS   = 6;
  localparam int unsigned LFSR_W = 16;

  localparam logic [2:0] LANE_L = 3'b001;
  localparam logic [2:0] LANE_M = 3'b010;
  localparam logic [2:0] LANE_R = 3'b100;

  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam logic [2:0] ROW_ALL      = 3'b111;
  localparam logic [2:0] ROW_ALL_MAP  = 3'b101;
  localparam logic [2:0] ROW_NONE     = 3'b000;
  localparam logic [2:0] ROW_NONE_MAP = 3'b010;

  // Full rows become passable, empty generated rows get a middle obstacle.
  function automatic logic [2:0] map_row(input logic [2:0] raw);
    logic [2:0] row;
    row = raw;
    if (raw == ROW_ALL)  row = ROW_ALL_MAP;
    if (raw == ROW_NONE) row = ROW_NONE_MAP;
    return row;
  endfunction

endpackage

// File: rtl/obs_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting left each cycle.
module obs_lfsr
  import obs_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] state
);

  // An all-zero seed would lock the register up.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_DEFAULT_SEED : SEED;

  always_ff @(posedge clk) begin
    if (reset) state <= SEED_EFF;
    else       state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/obstacle_field.sv
// Obstacle field: shifts generated rows down on each accepted tick, detects
// collisions and keeps the dodge score. OBS_SCORE_BCD_EN selects a packed-BCD score.
module obstacle_field #(
  parameter int unsigned ROWS      = 6,
  parameter int unsigned LANES     = 3,
  parameter int unsigned GAP_ROWS  = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    clear,
  input  logic [LANES-1:0]        player,
  output logic [ROWS*LANES-1:0]   field,
  output logic                    new_row,
  output logic                    hit,
  output logic [SCORE_W-1:0]      score
);

  localparam int unsigned FW    = ROWS * LANES;
  localparam int unsigned GAP_W = (GAP_ROWS > 0) ? $clog2(GAP_ROWS + 1) : 1;

  logic [obs_game_pkg::LFSR_W-1:0] lfsr;
  logic                            lfsr_unused_c;
  logic [GAP_W-1:0]                gap;
  logic [LANES-1:0]                bottom_c;
  logic                            overlap_c;
  logic                            accept_c;

  obs_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  assign lfsr_unused_c = ^lfsr[obs_game_pkg::LFSR_W-1:3];
  assign bottom_c      = field[FW-1 -: LANES];
  assign overlap_c     = |(bottom_c & player);
  assign accept_c      = tick && run && !clear;

  // Saturating increment; decimal carry per nibble in BCD mode.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] r;
`ifdef OBS_SCORE_BCD_EN
    logic carry;
    logic all9;
    r     = s;
    carry = 1'b1;
    all9  = 1'b1;
    for (int d = 0; d < int'(SCORE_W / 4); d++) begin
      if (r[4*d +: 4] != 4'd9) all9 = 1'b0;
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (all9) r = s;
`else
    r = (&s) ? s : s + SCORE_W'(1);
`endif
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      field   <= '0;
      gap     <= '0;
      score   <= '0;
      hit     <= 1'b0;
      new_row <= 1'b0;
    end else begin
      hit     <= run && overlap_c;
      new_row <= accept_c && (gap == '0);
      if (accept_c) begin
        if ((bottom_c != '0) && !overlap_c) score <= score_inc(score);
        // Row 0 sits in the low bits, so shifting down is a left shift of the vector.
        if (gap == '0) begin
          field <= {field[FW-LANES-1:0], obs_game_pkg::map_row(lfsr[2:0])};
          gap   <= GAP_W'(GAP_ROWS);
        end else begin
          field <= {field[FW-LANES-1:0], {LANES{1'b0}}};
          gap   <= gap - GAP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_obstacle_field.sv
// Bench for obstacle_field: randomized stimulus against a row-array reference model.
module tb_obstacle_field;

  localparam int unsigned ROWS     = 6;
  localparam int unsigned LANES    = 3;
  localparam int unsigned GAP_ROWS = 1;
  localparam int unsigned SCORE_W  = 8;
  localparam int unsigned FW       = ROWS * LANES;

  logic               clk;
  logic               reset, tick, run, clear;
  logic [LANES-1:0]   player;
  logic [FW-1:0]      field;
  logic               new_row, hit;
  logic [SCORE_W-1:0] score;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_lfsr = 16'h0;
  logic [2:0]  m_rows [ROWS];
  int          m_gap = 0;
  int          m_dodges = 0;
  bit          m_hit = 0;
  bit          m_new = 0;

  obstacle_field #(
    .ROWS(ROWS), .LANES(LANES), .GAP_ROWS(GAP_ROWS),
    .LFSR_SEED(16'hACE1), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .run(run), .clear(clear),
    .player(player), .field(field), .new_row(new_row), .hit(hit), .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ref_map(input logic [2:0] raw);
    case (raw)
      3'b111:  return 3'b101;
      3'b000:  return 3'b010;
      default: return raw;
    endcase
  endfunction

  function automatic logic [FW-1:0] exp_field();
    logic [FW-1:0] f;
    f = '0;
    for (int r = 0; r < int'(ROWS); r++) f[3*r +: 3] = m_rows[r];
    return f;
  endfunction

  function automatic int score_cap();
    int cap;
`ifdef OBS_SCORE_BCD_EN
    cap = 1;
    for (int d = 0; d < int'(SCORE_W / 4); d++) cap = cap * 10;
    cap = cap - 1;
`else
    cap = (1 << SCORE_W) - 1;
`endif
    return cap;
  endfunction

  function automatic logic [SCORE_W-1:0] exp_score();
    logic [SCORE_W-1:0] s;
    int v;
    v = (m_dodges > score_cap()) ? score_cap() : m_dodges;
`ifdef OBS_SCORE_BCD_EN
    s = '0;
    for (int d = 0; d < int'(SCORE_W / 4); d++) begin
      s[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
`else
    s = SCORE_W'(v);
`endif
    return s;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [15:0] l;
    logic [2:0]  bot;
    l   = m_lfsr;
    bot = m_rows[ROWS-1];
    if (reset) begin
      m_lfsr = 16'hACE1;
      foreach (m_rows[r]) m_rows[r] = 3'b000;
      m_gap = 0; m_dodges = 0; m_hit = 0; m_new = 0;
      return;
    end
    m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    if (clear) begin
      foreach (m_rows[r]) m_rows[r] = 3'b000;
      m_gap = 0; m_dodges = 0; m_hit = 0; m_new = 0;
      return;
    end
    m_hit = run && ((bot & player) != 3'b000);
    m_new = 0;
    if (tick && run) begin
      if (bot != 3'b000 && (bot & player) == 3'b000) m_dodges++;
      for (int r = ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
      if (m_gap == 0) begin
        m_rows[0] = ref_map(l[2:0]);
        m_gap = int'(GAP_ROWS);
        m_new = 1;
      end else begin
        m_rows[0] = 3'b000;
        m_gap--;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] free_lane(input logic [2:0] bot);
    logic [2:0] f;
    f = ~bot;
    return f & (~f + 3'd1);
  endfunction

  task automatic test_reset();
    reset = 1; tick = 0; run = 0; clear = 0; player = 3'b000;
    repeat (3) cycle();
    checks++; if (field !== '0) begin errors++; $display("FAIL reset_field: got %h want 0", field); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", hit); end
    checks++; if (score !== '0) begin errors++; $display("FAIL reset_score: got %h want 0", score); end
    checks++; if (new_row !== 1'b0) begin errors++; $display("FAIL reset_new_row: got %b want 0", new_row); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr); end
    reset = 0;
    cycle();
    checks++; if (dut.lfsr !== 16'h59C3) begin errors++; $display("FAIL lfsr_step: got %h want 59c3", dut.lfsr); end
  endtask

  task automatic test_gap_cadence();
    logic [FW-1:0] f;
    run = 1; player = 3'b000;
    for (int i = 1; i <= 6; i++) begin
      tick = 1; cycle(); tick = 0;
      checks++; if (new_row !== ((i % 2) == 1)) begin errors++; $display("FAIL gap_new_row tick%0d: got %b want %b", i, new_row, (i % 2) == 1); end
      cycle();
      checks++; if (new_row !== 1'b0) begin errors++; $display("FAIL gap_new_row_idle tick%0d: got %b want 0", i, new_row); end
      checks++; if (field !== exp_field()) begin errors++; $display("FAIL gap_field tick%0d: got %h want %h", i, field, exp_field()); end
    end
    // After six ticks the generated rows (ticks 1,3,5) sit in rows 5,3,1.
    f = field;
    for (int r = 0; r < int'(ROWS); r++) begin
      checks++;
      if ((f[3*r +: 3] != 3'b000) !== ((r % 2) == 1)) begin
        errors++; $display("FAIL gap_row%0d: got %b want %s", r, f[3*r +: 3], ((r % 2) == 1) ? "nonzero" : "000");
      end
    end
  endtask

  task automatic test_mapping();
    logic [2:0] tgt, want;
    int n;
    run = 1; player = 3'b000;
    for (int k = 0; k < 2; k++) begin
      tgt  = (k == 0) ? 3'b111 : 3'b000;
      want = (k == 0) ? 3'b101 : 3'b010;
      if (m_gap != 0) begin tick = 1; cycle(); tick = 0; end
      n = 0;
      while (m_lfsr[2:0] != tgt && n < 500) begin cycle(); n++; end
      checks++;
      if (n >= 500) begin
        errors++; $display("FAIL map_wait raw=%b: got timeout want lfsr match", tgt);
      end else begin
        tick = 1; cycle(); tick = 0;
        if (field[2:0] !== want) begin errors++; $display("FAIL map_raw%b: got %b want %b", tgt, field[2:0], want); end
      end
    end
  endtask

  task automatic test_collision();
    logic [2:0] bot, occ, fr;
    int n;
    run = 1; player = 3'b000; n = 0;
    while (m_rows[ROWS-1] == 3'b000 && n < 50) begin tick = 1; cycle(); n++; end
    tick = 0;
    bot = m_rows[ROWS-1];
    occ = bot & (~bot + 3'd1);
    fr  = free_lane(bot);
    checks++; if (field[FW-1 -: 3] === 3'b000) begin errors++; $display("FAIL coll_bottom: got 000 want nonzero"); end
    player = occ; cycle();
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL coll_hit player=%b bottom=%b: got %b want 1", occ, bot, hit); end
    player = fr; cycle();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL coll_move player=%b bottom=%b: got %b want 0", fr, bot, hit); end
    player = occ; run = 0; cycle();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL coll_run_low: got %b want 0", hit); end
    run = 1; cycle();
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL coll_run_high: got %b want 1", hit); end
    player = 3'b000; cycle();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL coll_no_player: got %b want 0", hit); end
  endtask

  task automatic test_score_saturation();
    logic [2:0] bot;
    logic [SCORE_W-1:0] sat;
    logic [FW-1:0] f;
    bit bad;
    int n;
    clear = 1; tick = 0; cycle(); clear = 0;
    checks++; if (score !== '0) begin errors++; $display("FAIL score_clear: got %h want 0", score); end
    n = 0;
    while (m_dodges <= score_cap() && n < 5000) begin
      bot = m_rows[ROWS-1];
      if ($urandom_range(3) != 0 && bot != 3'b000) player = free_lane(bot);
      else player = 3'($urandom);
      tick = ($urandom_range(3) != 0);
      run  = ($urandom_range(15) != 0);
      cycle(); n++;
      checks++;
      if ({field, score, hit, new_row} !== {exp_field(), exp_score(), m_hit, m_new}) begin
        errors++;
        $display("FAIL score_run cyc%0d: got f=%h s=%h h=%b n=%b want f=%h s=%h h=%b n=%b",
                 n, field, score, hit, new_row, exp_field(), exp_score(), m_hit, m_new);
      end
      f = field; bad = 0;
      for (int r = 0; r < int'(ROWS); r++) if (f[3*r +: 3] == 3'b111) bad = 1;
      checks++; if (bad) begin errors++; $display("FAIL no_full_row: got %h want no 111 row", f); end
    end
    checks++; if (n >= 5000) begin errors++; $display("FAIL score_budget: got %0d dodges want >%0d", m_dodges, score_cap()); end
`ifdef OBS_SCORE_BCD_EN
    sat = 8'h99;
`else
    sat = 8'hFF;
`endif
    checks++; if (score !== sat) begin errors++; $display("FAIL score_saturate: got %h want %h", score, sat); end
  endtask

  task automatic test_priority();
    run = 1; player = 3'b000;
    tick = 1; repeat (3) cycle();
    clear = 1; cycle(); clear = 0; tick = 0;
    checks++; if ({field, score, hit, new_row} !== '0) begin errors++; $display("FAIL prio_clear: got f=%h s=%h h=%b n=%b want all 0", field, score, hit, new_row); end
    tick = 1; repeat (4) cycle(); tick = 0;
    checks++; if (field !== exp_field()) begin errors++; $display("FAIL prio_refill: got %h want %h", field, exp_field()); end
    run = 0; tick = 1; cycle();
    checks++; if (field !== exp_field() || new_row !== 1'b0) begin errors++; $display("FAIL prio_run_low: got %h/%b want %h/0", field, new_row, exp_field()); end
    run = 1; reset = 1; cycle(); reset = 0; tick = 0;
    checks++; if ({field, score, hit, new_row} !== '0) begin errors++; $display("FAIL prio_reset: got f=%h s=%h want 0", field, score); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL prio_reset_lfsr: got %h want ace1", dut.lfsr); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      tick   = ($urandom_range(1) != 0);
      run    = ($urandom_range(7) != 0);
      clear  = ($urandom_range(15) == 0);
      reset  = ($urandom_range(63) == 0);
      player = 3'($urandom);
      cycle();
      checks++;
      if ({field, score, hit, new_row, dut.lfsr} !== {exp_field(), exp_score(), m_hit, m_new, m_lfsr}) begin
        errors++;
        $display("FAIL b2b cyc%0d: got f=%h s=%h h=%b n=%b l=%h want f=%h s=%h h=%b n=%b l=%h",
                 i, field, score, hit, new_row, dut.lfsr, exp_field(), exp_score(), m_hit, m_new, m_lfsr);
      end
    end
    reset = 0; clear = 0; tick = 0;
  endtask

  initial begin
    foreach (m_rows[r]) m_rows[r] = 3'b000;
    reset = 1; tick = 0; run = 0; clear = 0; player = 3'b000;
    test_reset();
    test_gap_cadence();
    test_mapping();
    test_collision();
    test_score_saturation();
    test_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
